out_i2s: RTL
============

// Module: out_i2s
// PURPOSE
//  I2S/left-justified serial transmitter toward the codec DAC; the transmit-side
//  counterpart of the ADC receiver. Accepts parallel stereo samples over a
//  valid/ready handshake into a one-deep holding buffer. Serialises each sample
//  MSB-first on DACDAT with DACLRC framing, clocked by the codec BCLK.
// PARAMETERS
//  DATA_WIDTH  24  bits per channel; frame = 2*DATA_WIDTH BCLK cycles
// PORTS
//  BCLK          in   1           bit clock; all state changes on posedge
//  reset         in   1           synchronous, active-high
//  enable        in   1           run request; sampled at frame boundaries
//  left_data     in   DATA_WIDTH  left sample, captured on accept
//  right_data    in   DATA_WIDTH  right sample, captured on accept
//  sample_valid  in   1           producer has a sample
//  sample_ready  out  1           holding buffer empty (= !buf_full)
//  underrun_clr  in   1           clears underrun flag
//  DACLRC        out  1           0 = left slot, 1 = right slot
//  DACDAT        out  1           serial data
//  frame_start   out  1           1-cycle pulse when left MSB slot begins
//  underrun      out  1           sticky: frame began with empty buffer
// BEHAVIOUR
//  Reset: state IDLE, counter=0, buf_full=0 (sample_ready=1), DACLRC=0,
//   DACDAT=0, frame_start=0, underrun=0, shift reg=0. Reset mid-frame aborts
//   the frame at once; buffered sample is discarded.
//  Accept: sample_valid && sample_ready at posedge -> {left,right} to buffer,
//   buf_full=1. sample_ready is combinational !buf_full.
//  States: IDLE, RUN. Counter 0..2*DATA_WIDTH-1.
//  IDLE: DACLRC=0, DACDAT=0. Leaves only when enable && buf_full: at that
//   edge load shift reg from buffer, buf_full=0, counter=0, state RUN;
//   registered outputs after this edge: DACLRC=0, DACDAT=left[MSB],
//   frame_start=1.
//  RUN: each posedge counter+1; DACLRC = (counter >= DATA_WIDTH); DACDAT
//   shifts out left MSB..LSB then right MSB..LSB. First data within one cycle
//   of frame_start; frame period exactly 2*DATA_WIDTH cycles, no gaps.
//  Frame boundary (edge after counter = 2*DATA_WIDTH-1):
//   - enable=0: state IDLE, DACLRC=0, DACDAT=0; buffer retained.
//   - enable=1, buf_full=1: load buffer, buf_full=0, counter=0, frame_start=1.
//   - enable=1, buf_full=0: load zeros, underrun=1, counter=0, frame_start=1.
//  Simultaneous accept and boundary with empty buffer: no bypass; the
//   boundary sees the buffer empty (underrun, zero frame), and the accepted
//   sample plays next frame.
//  Buffer full: sample_ready=0 until the next boundary load. enable drop
//   mid-frame has no effect until the boundary.
//  underrun: set as above, cleared by underrun_clr; set wins if same edge.
// CONFIGURATION
//  OUT_I2S_DELAY_EN defined: Philips I2S format. DACDAT is delayed one BCLK
//   through an extra flop; DACLRC timing unchanged, so each slot's MSB appears
//   one cycle after the DACLRC edge. The right LSB appears in cycle 0 of the
//   next frame, or in the first IDLE cycle, then 0.
//  Undefined: left-justified; MSB coincides with the DACLRC edge.
// TESTING
//  1 Reset, load L=24'hA5A5A5 R=24'h5A5A5A, enable=1 -> frame_start pulse,
//    DACLRC low 24 cycles then high 24, DACDAT bit-exact MSB-first.
//  2 Continuous feed, 4 frames of distinct samples -> gapless 48-cycle
//    frames, sample_ready returns high at each boundary, underrun stays 0.
//  3 Withhold second sample -> frame 2 all-zero DACDAT, underrun=1 held
//    until underrun_clr pulse; frame 3 plays the late sample.
//  4 enable=0 at counter=10 -> frame completes, then IDLE with DACLRC=0
//    DACDAT=0; buffered sample plays first when enable returns.
//  5 reset at counter=30 -> next cycle all outputs at reset values,
//    sample_ready=1.
//  6 OUT_I2S_DELAY_EN build, case 1 -> DACDAT equals case 1 stream delayed
//    one cycle; bit 0 of R appears in the first cycle after the frame.

Source files
------------

// File: rtl/out_i2s.sv
// Left-justified / Philips I2S serial transmitter toward a codec DAC, clocked by BCLK.
// Define OUT_I2S_DELAY_EN for Philips I2S (DACDAT lags DACLRC by one BCLK).
module out_i2s #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  BCLK,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  underrun_clr,
  output logic                  DACLRC,
  output logic                  DACDAT,
  output logic                  frame_start,
  output logic                  underrun,
  output logic [0:0]            o_dbg_state
);

  localparam int FRAME = 2 * DATA_WIDTH;
  localparam int CW    = $clog2(FRAME);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DATA_WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [FRAME-1:0] r_buf;
  logic             r_buf_full;
  logic [FRAME-1:0] r_shift;
  logic             r_fs;
  logic             r_underrun;

  logic w_accept;
  logic w_boundary;
  logic w_start;
  logic w_load_buf;
  logic w_underrun_set;
  logic w_dat_raw;

  // A frame starts from IDLE only with a sample in hand; at a boundary it starts
  // regardless and plays zeros if the buffer is empty.
  always_comb begin
    w_accept       = sample_valid && !r_buf_full;
    w_boundary     = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
    w_start        = enable && (((r_state == ST_IDLE) && r_buf_full) || w_boundary);
    w_load_buf     = w_start && r_buf_full;
    w_underrun_set = w_start && !r_buf_full;
    w_dat_raw      = r_shift[FRAME-1];
  end

  always_ff @(posedge BCLK) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_fs       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_fs <= w_start;

      // Accept and buffer load are exclusive: accept needs an empty buffer.
      if (w_accept) begin
        r_buf      <= {left_data, right_data};
        r_buf_full <= 1'b1;
      end else if (w_load_buf) begin
        r_buf_full <= 1'b0;
      end

      if (w_start) begin
        r_state <= ST_RUN;
        r_cnt   <= '0;
        r_shift <= w_load_buf ? r_buf : '0;
      end else if (w_boundary) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (r_state == ST_RUN) begin
        r_cnt   <= r_cnt + 1'b1;
        r_shift <= {r_shift[FRAME-2:0], 1'b0};
      end

      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

`ifdef OUT_I2S_DELAY_EN
  logic r_dly;

  always_ff @(posedge BCLK) begin
    if (reset) begin
      r_dly <= 1'b0;
    end else begin
      r_dly <= w_dat_raw;
    end
  end

  assign DACDAT = r_dly;
`else
  assign DACDAT = w_dat_raw;
`endif

  assign sample_ready = !r_buf_full;
  assign DACLRC       = (r_state == ST_RUN) && (r_cnt >= CNT_HALF);
  assign frame_start  = r_fs;
  assign underrun     = r_underrun;
  assign o_dbg_state  = r_state;

endmodule
